// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Function : Samples a scanned active-low 7-segment bus, waits for each
//            pattern to settle, and decodes it back to a per-digit value.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] digits_out,
    output logic [NDIG-1:0]   digit_valid,
    output logic              update,
    output logic              err
);

    localparam int            CW      = $clog2(STABLE + 1);
    localparam int            SW      = NDIG + 7;
    localparam logic [CW-1:0] C_LAST  = CW'(STABLE - 1);
    localparam logic [CW-1:0] C_MAX   = CW'(STABLE);
    localparam logic [SW-1:0] C_S_RST = {{NDIG{1'b0}}, 7'h7F};

    typedef enum logic [0:0] {
        ST_CHANGING = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              update_q, update_d;
    logic              err_q, err_d;

    logic [SW-1:0]     w_in;
    logic              w_same;
    logic              w_accept;
    logic              w_onehot;
    logic              w_legal;
    logic              w_blank;
    logic [3:0]        w_val;

    assign w_in     = {dig_sel, seg_in};
    assign w_same   = (w_in == s_q);
    assign w_accept = w_same && (state_q == ST_CHANGING) && (cnt_q == C_LAST);
    assign w_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    assign w_blank  = (seg_in == 7'h7F);

    always_comb begin
        w_legal = 1'b1;
        w_val   = 4'h0;
        case (seg_in)
            7'b1000000: w_val = 4'd0;
            7'b1111001: w_val = 4'd1;
            7'b0100100: w_val = 4'd2;
            7'b0110000: w_val = 4'd3;
            7'b0011001: w_val = 4'd4;
            7'b0010010: w_val = 4'd5;
            7'b0000010: w_val = 4'd6;
            7'b1011000: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0010000: w_val = 4'd9;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        err_d    = 1'b0;

        // Any change restarts the run; an unchanged sample counts up and saturates.
        if (!w_same) begin
            s_d     = w_in;
            cnt_d   = '0;
            state_d = ST_CHANGING;
        end else if (cnt_q != C_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (w_accept) begin
            state_d = ST_LOCKED;
            if (w_onehot) begin
                if (w_legal || w_blank) begin
                    update_d = 1'b1;
                    for (int i = 0; i < NDIG; i++) begin
                        if (dig_sel[i]) begin
                            digits_d[4*i +: 4] = w_blank ? 4'hF : w_val;
                            valid_d[i]         = !w_blank;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CHANGING;
            s_q      <= C_S_RST;
            cnt_q    <= '0;
            digits_q <= '1;
            valid_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Function : Bench for seg7_scan_decoder: directed scenarios plus random
//            held patterns, compared every cycle against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic [6:0]        seg_in  = 7'h7F;
    logic [NDIG-1:0]   dig_sel = '0;
    logic [4*NDIG-1:0] digits_out;
    logic [NDIG-1:0]   digit_valid;
    logic              update;
    logic              err;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int upd_seen    = 0;
    int err_seen    = 0;
    bit chk_on      = 1'b0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};

    // Reference model: length of the current run of identical samples.
    logic [3:0]        m_dig [NDIG];
    bit                m_val [NDIG];
    bit                m_upd;
    bit                m_err;
    logic [NDIG+6:0]   m_prev;
    int                m_run;

    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 10; k++) if (pat[k] == p) return k;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                m_dig[i] = 4'hF;
                m_val[i] = 1'b0;
            end
            m_upd  = 1'b0;
            m_err  = 1'b0;
            m_prev = {{NDIG{1'b0}}, 7'h7F};
            m_run  = 0;
        end else begin
            m_upd = 1'b0;
            m_err = 1'b0;
            if ({dig_sel, seg_in} != m_prev) begin
                m_prev = {dig_sel, seg_in};
                m_run  = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run == STABLE && $countones(dig_sel) == 1) begin
                    int idx;
                    int code;
                    idx  = 0;
                    for (int i = 0; i < NDIG; i++) if (dig_sel[i]) idx = i;
                    code = lookup(seg_in);
                    if (code >= 0) begin
                        m_dig[idx] = 4'(code);
                        m_val[idx] = 1'b1;
                        m_upd      = 1'b1;
                    end else if (seg_in == 7'h7F) begin
                        m_dig[idx] = 4'hF;
                        m_val[idx] = 1'b0;
                        m_upd      = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [4*NDIG-1:0] exp_d;
            logic [NDIG-1:0]   exp_v;
            for (int i = 0; i < NDIG; i++) begin
                exp_d[4*i +: 4] = m_dig[i];
                exp_v[i]        = m_val[i];
            end
            vectors++;
            if (digits_out !== exp_d || digit_valid !== exp_v || update !== m_upd || err !== m_err) begin
                miscompares++;
                $display("FAIL cycle t=%0t digits=%h/%h valid=%b/%b update=%b/%b err=%b/%b (got/exp)",
                         $time, digits_out, exp_d, digit_valid, exp_v, update, m_upd, err, m_err);
            end
            upd_seen += int'(update);
            err_seen += int'(err);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [NDIG-1:0] sel, input logic [6:0] seg, input int n);
        repeat (n) begin
            @(negedge clk);
            dig_sel = sel;
            seg_in  = seg;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_digits"}, 32'(digits_out), 32'hFFFF);
        chk({nm, "_valid"},  32'(digit_valid), 32'h0);
        chk({nm, "_update"}, 32'(update), 32'h0);
        chk({nm, "_err"},    32'(err), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int bu;
        int be;
        logic [6:0] sc [4];
        sc[0] = pat[1]; sc[1] = pat[2]; sc[2] = pat[3]; sc[3] = pat[4];

        repeat (2) @(negedge clk);
        chk_reset("init_reset");
        #2 rst_n = 1'b1;
        chk_on = 1'b1;

        // Legal numeral, then long hold must not pulse again
        bu = upd_seen;
        step(4'b0001, pat[2], 5);
        settle();
        chk("num_digit0", 32'(digits_out[3:0]), 32'h2);
        chk("num_valid",  32'(digit_valid), 32'b0001);
        chk("num_updates", 32'(upd_seen - bu), 32'd1);
        step(4'b0001, pat[2], 20);
        settle();
        chk("hold_updates", 32'(upd_seen - bu), 32'd1);

        // Glitch: four edges is one short of acceptance
        bu = upd_seen;
        step(4'b0010, pat[3], 4);
        step(4'b0010, pat[1], 2);
        step(4'b0000, 7'h7F, 2);
        settle();
        chk("glitch_updates", 32'(upd_seen - bu), 32'd0);
        chk("glitch_digit1", 32'(digits_out[7:4]), 32'hF);

        // Blank and illegal codes on digit 2
        step(4'b0100, pat[7], 6);
        settle();
        chk("load7_digit2", 32'(digits_out[11:8]), 32'h7);
        bu = upd_seen;
        step(4'b0100, 7'h7F, 5);
        settle();
        chk("blank_digit2", 32'(digits_out[11:8]), 32'hF);
        chk("blank_valid2", 32'(digit_valid[2]), 32'h0);
        chk("blank_updates", 32'(upd_seen - bu), 32'd1);
        bu = upd_seen;
        be = err_seen;
        step(4'b0100, 7'b0000001, 5);
        settle();
        chk("illegal_errs", 32'(err_seen - be), 32'd1);
        chk("illegal_updates", 32'(upd_seen - bu), 32'd0);
        chk("illegal_digits", 32'(digits_out), 32'hFFF2);

        // Multi-hot and empty select
        bu = upd_seen;
        be = err_seen;
        step(4'b0011, pat[0], 10);
        step(4'b0000, pat[0], 10);
        settle();
        chk("badsel_updates", 32'(upd_seen - bu), 32'd0);
        chk("badsel_errs", 32'(err_seen - be), 32'd0);
        chk("badsel_digits", 32'(digits_out), 32'hFFF2);
        chk("badsel_valid", 32'(digit_valid), 32'b0001);

        // Full scan, two clean rounds
        for (int r = 0; r < 2; r++) begin
            bu = upd_seen;
            for (int d = 0; d < 4; d++) step(4'(1 << d), sc[d], 8);
            settle();
            chk("scan_round_updates", 32'(upd_seen - bu), 32'd4);
        end
        chk("scan_digits", 32'(digits_out), 32'h4321);
        chk("scan_valid",  32'(digit_valid), 32'b1111);

        // Third round interrupted by reset mid-run
        step(4'b0001, sc[0], 8);
        step(4'b0010, sc[1], 8);
        step(4'b0100, sc[2], 3);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step(4'b0100, sc[2], 8);
        step(4'b1000, sc[3], 8);
        for (int d = 0; d < 4; d++) step(4'(1 << d), sc[d], 8);
        settle();
        chk("recap_digits", 32'(digits_out), 32'h4321);
        chk("recap_valid",  32'(digit_valid), 32'b1111);

        // Random held patterns
        repeat (300) begin
            int r;
            logic [NDIG-1:0] sel;
            logic [6:0]      seg;
            r = int'($urandom_range(0, 99));
            if (r < 70)      sel = NDIG'(1) << $urandom_range(0, NDIG-1);
            else if (r < 85) sel = '0;
            else             sel = NDIG'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 55)      seg = pat[$urandom_range(0, 9)];
            else if (r < 70) seg = 7'h7F;
            else             seg = 7'($urandom);
            step(sel, seg, int'($urandom_range(1, 8)));
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
